// File: rtl/first_nios2_system_lcd_sequencer.sv
// first_nios2_system_lcd_sequencer: Avalon-MM byte FIFO draining into timed HD44780 bus cycles.
// Define LCD_BUSY_POLL_EN to replace the fixed post-byte delay with busy-flag polling.
module first_nios2_system_lcd_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int SETUP_CYC  = 4,
  parameter int E_HIGH_CYC = 25,
  parameter int HOLD_CYC   = 2,
  parameter int EXEC_CYC   = 2500,
  parameter int CLEAR_CYC  = 82000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       write,
  input  logic [7:0] writedata,
  input  logic       read,
  output logic [7:0] readdata,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int MAXC = CLEAR_CYC > EXEC_CYC ? CLEAR_CYC : EXEC_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, HOLD, EXEC} state_t;
  state_t state;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [LW-1:0] level;
  logic [CW-1:0] cnt, exec_last;
  logic [7:0] data_q;
  logic overflow, empty, full, pop, push_req, push;
  assign empty    = level == '0;
  assign full     = level == LW'(FIFO_DEPTH);
  assign pop      = state == IDLE && !empty;
  assign push_req = write && !address[1];
  assign push     = push_req && (!full || pop);
  // Clear/home instructions need the long execution delay
  assign exec_last = (!LCD_RS && data_q >= 8'h01 && data_q <= 8'h03) ? CW'(CLEAR_CYC - 1) : CW'(EXEC_CYC - 1);
`ifdef LCD_BUSY_POLL_EN
  logic bf;
  logic [CW-1:0] poll_cnt;
  assign LCD_data = LCD_RW ? 8'hzz : data_q;
`else
  assign LCD_RW   = 1'b0;
  assign LCD_data = data_q;
`endif
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {address[0], writedata};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      readdata <= 8'h00;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      data_q   <= 8'h00;
`ifdef LCD_BUSY_POLL_EN
      LCD_RW   <= 1'b0;
      bf       <= 1'b0;
      poll_cnt <= '0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (write && address == 2'd2 && writedata[0]) overflow <= 1'b0;
      else if (push_req && !push) overflow <= 1'b1;
      if (read) readdata <= address == 2'd2 ? {4'b0, overflow, full, empty, state != IDLE} :
                            address == 2'd3 ? 8'(level) : 8'h00;
      cnt <= cnt + CW'(1);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pop) begin
            state  <= SETUP;
            LCD_RS <= mem[rd_ptr][8];
            data_q <= mem[rd_ptr][7:0];
          end
        end
        SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
          state <= E_HIGH;
          LCD_E <= 1'b1;
          cnt   <= '0;
        end
        E_HIGH: if (cnt == CW'(E_HIGH_CYC - 1)) begin
          state <= HOLD;
          LCD_E <= 1'b0;
          cnt   <= '0;
`ifdef LCD_BUSY_POLL_EN
          bf    <= LCD_data[7];
`endif
        end
        HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
          cnt <= '0;
`ifdef LCD_BUSY_POLL_EN
          if (LCD_RW && !bf) begin
            state  <= IDLE;
            LCD_RW <= 1'b0;
          end else begin
            state  <= SETUP;
            LCD_RW <= 1'b1;
            LCD_RS <= 1'b0;
          end
`else
          state <= EXEC;
`endif
        end
        EXEC: if (cnt == exec_last) begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
`ifdef LCD_BUSY_POLL_EN
      poll_cnt <= LCD_RW ? poll_cnt + CW'(1) : '0;
      // A display that never clears BF must not wedge the queue
      if (LCD_RW && poll_cnt == CW'(CLEAR_CYC - 1)) begin
        state  <= IDLE;
        LCD_RW <= 1'b0;
        LCD_E  <= 1'b0;
        cnt    <= '0;
      end
`endif
    end
endmodule
